// File: rtl/commit_ctrl_pkg.sv
// commit_ctrl_pkg: shared head-type encodings, FSM states and bus widths for the commit sequencer
package commit_ctrl_pkg;
    localparam int DATA_BUS = 32;
    localparam int REG_BUS  = 5;
    localparam int ROB_BUS  = 5;

    typedef enum logic [1:0] {
        TYPE_REG  = 2'd0,
        TYPE_BR   = 2'd1,
        TYPE_JALR = 2'd2,
        TYPE_ST   = 2'd3
    } head_type_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;
endpackage

// File: rtl/commit_ctrl_if.sv
// commit_ctrl_if: ROB head, Regfile commit port, LSB store handshake and IF redirect signals
interface commit_ctrl_if
    import commit_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_BUS,
    parameter int REG_W  = REG_BUS,
    parameter int ROB_W  = ROB_BUS
) ();
    logic              head_valid;
    logic              head_ready;
    logic [1:0]        head_type;
    logic [REG_W-1:0]  head_rd;
    logic [ROB_W-1:0]  head_tag;
    logic [DATA_W-1:0] head_result;
    logic              head_mispredict;
    logic [DATA_W-1:0] head_target_pc;
    logic              head_pop;
    logic              ROB_write_S;
    logic [REG_W-1:0]  ROB_rd;
    logic [ROB_W-1:0]  ROB_Reorder;
    logic [DATA_W-1:0] ROB_result;
    logic              st_req;
    logic [ROB_W-1:0]  st_tag;
    logic              st_ack;
    logic              clr;
    logic              redirect_S;
    logic [DATA_W-1:0] redirect_pc;

    modport master (
        input  head_valid, head_ready, head_type, head_rd, head_tag, head_result,
               head_mispredict, head_target_pc, st_ack,
        output head_pop, ROB_write_S, ROB_rd, ROB_Reorder, ROB_result,
               st_req, st_tag, clr, redirect_S, redirect_pc
    );

    modport slave (
        output head_valid, head_ready, head_type, head_rd, head_tag, head_result,
               head_mispredict, head_target_pc, st_ack,
        input  head_pop, ROB_write_S, ROB_rd, ROB_Reorder, ROB_result,
               st_req, st_tag, clr, redirect_S, redirect_pc
    );
endinterface

// File: rtl/commit_ctrl.sv
// commit_ctrl: in-order ROB retirement sequencer; define COMMIT_PERF_EN to add commit/flush perf counters
module commit_ctrl
    import commit_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
`ifdef COMMIT_PERF_EN
    output logic [31:0] perf_commits,
    output logic [15:0] perf_flushes,
`endif
    commit_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    head_type_t       ty;
    logic             commit, is_st, writes, mispredict;

    assign ty         = head_type_t'(bus.head_type);
    assign commit     = state == IDLE && bus.head_valid && bus.head_ready;
    assign is_st      = ty == TYPE_ST;
    assign writes     = commit && (ty == TYPE_REG || ty == TYPE_JALR);
    assign mispredict = commit && bus.head_mispredict && (ty == TYPE_BR || ty == TYPE_JALR);

    // state register: frozen while the pipeline is not ready
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (rdy) begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // next-state: stores wait for ack, mispredicts hold the flush for FLUSH_CYCLES
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (commit && is_st) begin
                    state_n = ST_WAIT;
                end else if (mispredict) begin
                    state_n = FLUSH;
                    cnt_n   = CNT_W'(FLUSH_CYCLES - 1);
                end
            end
            ST_WAIT: state_n = bus.st_ack ? IDLE : ST_WAIT;
            FLUSH: begin
                if (cnt == '0) state_n = IDLE;
                else cnt_n = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // head pop: stores retire only on ack, everything else retires on acceptance
    always_comb begin
        bus.head_pop = rdy && (state == ST_WAIT ? bus.st_ack : commit && !is_st);
    end

    // registered commit port, store request and flush/redirect outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.ROB_write_S <= 1'b0;
            bus.ROB_rd      <= '0;
            bus.ROB_Reorder <= '0;
            bus.ROB_result  <= '0;
            bus.st_req      <= 1'b0;
            bus.st_tag      <= '0;
            bus.clr         <= 1'b0;
            bus.redirect_S  <= 1'b0;
            bus.redirect_pc <= '0;
        end else begin
            bus.ROB_write_S <= rdy && writes;
            bus.redirect_S  <= rdy && mispredict;
            if (rdy) begin
                bus.clr    <= state_n == FLUSH;
                bus.st_req <= state_n == ST_WAIT;
            end
            if (rdy && writes) begin
                bus.ROB_rd      <= bus.head_rd;
                bus.ROB_Reorder <= bus.head_tag;
                bus.ROB_result  <= bus.head_result;
            end
            if (rdy && mispredict) bus.redirect_pc <= bus.head_target_pc;
            if (rdy && commit && is_st) bus.st_tag <= bus.head_tag;
        end
    end

`ifdef COMMIT_PERF_EN
    // performance counters: retired heads and mispredict flushes, wrapping
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_commits <= '0;
            perf_flushes <= '0;
        end else if (rdy) begin
            perf_commits <= perf_commits + 32'(bus.head_pop);
            perf_flushes <= perf_flushes + 16'(mispredict);
        end
    end
`endif
endmodule

// File: tb/tb_commit_ctrl.sv
// tb_commit_ctrl: directed plus randomized checks of commit_ctrl against a retirement-rule model
module tb_commit_ctrl;
    import commit_ctrl_pkg::*;

    localparam int FC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rdy = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    commit_ctrl_if bus ();

`ifdef COMMIT_PERF_EN
    logic [31:0] perf_commits;
    logic [15:0] perf_flushes;
    commit_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .perf_commits(perf_commits), .perf_flushes(perf_flushes), .bus(bus));
`else
    commit_ctrl #(.FLUSH_CYCLES(FC)) dut (.clk(clk), .rst(rst), .rdy(rdy), .bus(bus));
`endif

    // reference model: pending store, remaining flush cycles, expected registered outputs
    bit          st_pend = 0;
    int          fl = 0;
    bit          e_we = 0, e_redir = 0;
    logic [4:0]  e_rd = '0, e_reo = '0, e_st_tag = '0;
    logic [31:0] e_res = '0, e_pc = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        bit p = 0;
        if (!rst) begin
            st_pend = 0; fl = 0; e_we = 0; e_redir = 0;
            e_rd = '0; e_reo = '0; e_st_tag = '0; e_res = '0; e_pc = '0;
        end else if (!rdy) begin
            e_we = 0; e_redir = 0;
        end else begin
            e_we = 0; e_redir = 0;
            if (st_pend) begin
                p = bus.st_ack;
                st_pend = !bus.st_ack;
            end else if (fl > 0) begin
                fl--;
            end else if (bus.head_valid && bus.head_ready) begin
                if (bus.head_type == 2'd3) begin
                    st_pend = 1;
                    e_st_tag = bus.head_tag;
                end else begin
                    p = 1;
                    if (bus.head_type != 2'd1) begin
                        e_we = 1; e_rd = bus.head_rd; e_reo = bus.head_tag; e_res = bus.head_result;
                    end
                    if (bus.head_type != 2'd0 && bus.head_mispredict) begin
                        e_redir = 1; e_pc = bus.head_target_pc; fl = FC;
                    end
                end
            end
        end
        #1;
        if (rst) check("head_pop", bus.head_pop, p);
        @(posedge clk);
        #1;
        check("ROB_write_S", bus.ROB_write_S, e_we);
        check("ROB_rd", bus.ROB_rd, e_rd);
        check("ROB_Reorder", bus.ROB_Reorder, e_reo);
        check("ROB_result", bus.ROB_result, e_res);
        check("st_req", bus.st_req, st_pend);
        check("st_tag", bus.st_tag, e_st_tag);
        check("clr", bus.clr, fl > 0);
        check("redirect_S", bus.redirect_S, e_redir);
        check("redirect_pc", bus.redirect_pc, e_pc);
    endtask

    task automatic go(input bit r, input bit y, input bit v, input bit hr, input logic [1:0] ty,
                      input logic [4:0] rd, input logic [4:0] tg, input logic [31:0] res,
                      input bit m, input logic [31:0] pc, input bit ak);
        rst = r; rdy = y;
        bus.head_valid = v; bus.head_ready = hr; bus.head_type = ty; bus.head_rd = rd;
        bus.head_tag = tg; bus.head_result = res; bus.head_mispredict = m;
        bus.head_target_pc = pc; bus.st_ack = ak;
        cycle();
    endtask

    initial begin
        // reset, then a single REG commit
        go(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        go(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        go(1, 1, 1, 1, 0, 5, 3, 32'hDEADBEEF, 0, 0, 0);
        go(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // back-to-back REG commits
        for (int i = 1; i <= 3; i++) go(1, 1, 1, 1, 0, 5'(i + 8), 5'(i), 32'(i * 100), 0, 0, 0);
        go(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // store handshake, ack arrives in the fourth waiting cycle
        go(1, 1, 1, 1, 3, 0, 7, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) go(1, 1, 1, 1, 3, 0, 7, 0, 0, 0, 0);
        go(1, 1, 1, 1, 3, 0, 7, 0, 0, 0, 1);
        go(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // JALR mispredict with a write, then flush cycles that block retirement
        go(1, 1, 1, 1, 2, 1, 9, 32'h104, 1, 32'h2000, 0);
        go(1, 1, 1, 1, 0, 2, 10, 32'h55, 0, 0, 0);
        go(1, 1, 1, 1, 0, 2, 10, 32'h55, 0, 0, 0);
        go(1, 1, 1, 1, 0, 2, 10, 32'h55, 0, 0, 0);
        // non-mispredicted branch, rd 0 write, BR mispredict
        go(1, 1, 1, 1, 1, 0, 11, 0, 0, 32'h40, 0);
        go(1, 1, 1, 1, 0, 0, 12, 32'h77, 0, 0, 0);
        go(1, 1, 1, 1, 1, 0, 13, 0, 1, 32'h80, 0);
        go(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        go(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // stall with a ready REG head, then release
        go(1, 0, 1, 1, 0, 4, 5, 32'h1234, 0, 0, 0);
        go(1, 0, 1, 1, 0, 4, 5, 32'h1234, 0, 0, 0);
        go(1, 1, 1, 1, 0, 4, 5, 32'h1234, 0, 0, 0);
        // reset while waiting for a store ack; a late ack must not pop
        go(1, 1, 1, 1, 3, 0, 14, 0, 0, 0, 0);
        go(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        go(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        // randomized traffic
        for (int i = 0; i < 800; i++)
            go(($urandom % 40) != 0, ($urandom % 5) != 0, ($urandom % 4) != 0, ($urandom % 4) != 0,
               2'($urandom % 4), 5'($urandom), 5'($urandom), $urandom, ($urandom % 2) != 0,
               $urandom, ($urandom % 3) == 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
